error_stage: RTL and testbench

- Sits directly downstream of a single trainable node.
- Consumes the node's forward activation and pairs it with a target sample from a separate target stream.
- Computes the signed error (target - activation) and returns it to the node's backward input.
- Keeps a running sum of squared errors and a sample count for monitoring.
- In inference mode (train low) it sinks activations one per cycle and produces no backward traffic.

---
 rtl/error_stage.sv | 119 +++++++++++
 tb/tb_error_stage.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/error_stage.sv
// Loss stage behind a single trainable node. It pairs each activation with a target,
// returns the signed error upstream, and tracks a saturating sum of squared errors and a sample count.
module error_stage #(
  parameter int unsigned W  = 8,
  parameter int unsigned CW = 16,
  parameter int unsigned LW = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          train,
  input  logic          clear,
  input  logic          input_forward_valid,
  input  logic [W-1:0]  input_forward_data,
  output logic          input_forward_ready,
  input  logic          target_valid,
  input  logic [W-1:0]  target_data,
  output logic          target_ready,
  output logic          output_backward_valid,
  output logic [15:0]   output_backward_data,
  input  logic          output_backward_ready,
  output logic [LW-1:0] loss,
  output logic [CW-1:0] count
);

  localparam int unsigned EW = 16;
  localparam int unsigned SQW = 2 * W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR,
    ST_BWD
  } state_t;

  state_t         state;
  logic [W-1:0]   act;
  logic [W-1:0]   tgt;
  logic           tgt_full;

  logic           act_hs;
  logic           tgt_hs;
  logic [EW-1:0]  err_val;
  logic [W-1:0]   err_mag;
  logic [SQW-1:0] err_sq;
  logic [LW:0]    loss_sum;
  logic [LW-1:0]  loss_next;
  logic [CW-1:0]  count_next;

  assign input_forward_ready = (state == ST_IDLE);
  assign target_ready        = !tgt_full && ((state == ST_IDLE) || (state == ST_WAIT));
  assign act_hs              = input_forward_valid && input_forward_ready;
  assign tgt_hs              = target_valid && target_ready;

  // Error arithmetic. The square is formed from the magnitude, so the product is always unsigned.
  always_comb begin
    err_val    = EW'(tgt) - EW'(act);
    err_mag    = (tgt >= act) ? (tgt - act) : (act - tgt);
    err_sq     = SQW'(err_mag) * SQW'(err_mag);
    loss_sum   = {1'b0, loss} + (LW + 1)'(err_sq);
    loss_next  = loss_sum[LW] ? {LW{1'b1}} : loss_sum[LW-1:0];
    count_next = (count == {CW{1'b1}}) ? count : count + CW'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state                 <= ST_IDLE;
      act                   <= '0;
      tgt                   <= '0;
      tgt_full              <= 1'b0;
      output_backward_valid <= 1'b0;
      output_backward_data  <= '0;
      loss                  <= '0;
      count                 <= '0;
    end else begin
      if (tgt_hs) begin
        tgt      <= target_data;
        tgt_full <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (act_hs) begin
            act <= input_forward_data;
            if (train) begin
              state <= (tgt_full || tgt_hs) ? ST_ERR : ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (tgt_hs) begin
            state <= ST_ERR;
          end
        end
        ST_ERR: begin
          output_backward_data  <= err_val;
          output_backward_valid <= 1'b1;
          tgt_full              <= 1'b0;
          loss                  <= loss_next;
          count                 <= count_next;
          state                 <= ST_BWD;
        end
        ST_BWD: begin
          if (output_backward_ready) begin
            output_backward_valid <= 1'b0;
            state                 <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      // A clear takes priority over the ERR-cycle accumulation.
      if (clear) begin
        loss  <= '0;
        count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_error_stage.sv
// Directed bench for error_stage: training, target-first, backpressure, inference,
// saturation with clear, and asynchronous reset.
module tb_error_stage;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = 16;
  localparam int unsigned LW = 20;

  logic          clock;
  logic          reset;
  logic          train;
  logic          clear;
  logic          ifv;
  logic [W-1:0]  ifd;
  logic          ifr;
  logic          tv;
  logic [W-1:0]  td;
  logic          tr;
  logic          obv;
  logic [15:0]   obd;
  logic          obr;
  logic [LW-1:0] loss;
  logic [CW-1:0] count;

  int n_cmp = 0;
  int n_bad = 0;

  error_stage #(.W(W), .CW(CW), .LW(LW)) dut (
    .clock                 (clock),
    .reset                 (reset),
    .train                 (train),
    .clear                 (clear),
    .input_forward_valid   (ifv),
    .input_forward_data    (ifd),
    .input_forward_ready   (ifr),
    .target_valid          (tv),
    .target_data           (td),
    .target_ready          (tr),
    .output_backward_valid (obv),
    .output_backward_data  (obd),
    .output_backward_ready (obr),
    .loss                  (loss),
    .count                 (count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0; train = 1'b0; clear = 1'b0;
    ifv = 1'b0; ifd = '0; tv = 1'b0; td = '0; obr = 1'b0;
    #3;
    n_cmp++; if (obv !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", obv); end
    n_cmp++; if (obd !== 16'h0000) begin n_bad++; $display("FAIL reset_data: got %h want 0000", obd); end
    n_cmp++; if (loss !== 20'd0) begin n_bad++; $display("FAIL reset_loss: got %0d want 0", loss); end
    n_cmp++; if (count !== 16'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", count); end
    n_cmp++; if (ifr !== 1'b1) begin n_bad++; $display("FAIL reset_ifr: got %b want 1", ifr); end
    n_cmp++; if (tr !== 1'b1) begin n_bad++; $display("FAIL reset_tr: got %b want 1", tr); end
    tick; tick;
    reset = 1'b1;
    tick;
  endtask

  task automatic test_basic;
    ifv = 1'b1; ifd = 8'hC0; tv = 1'b1; td = 8'h40; train = 1'b1;
    tick;
    ifv = 1'b0; tv = 1'b0;
    n_cmp++; if (obv !== 1'b0) begin n_bad++; $display("FAIL basic_err_cycle_valid: got %b want 0", obv); end
    tick;
    n_cmp++; if (obv !== 1'b1) begin n_bad++; $display("FAIL basic_valid: got %b want 1", obv); end
    n_cmp++; if (obd !== 16'hFF80) begin n_bad++; $display("FAIL basic_data: got %h want FF80", obd); end
    n_cmp++; if (loss !== 20'd16384) begin n_bad++; $display("FAIL basic_loss: got %0d want 16384", loss); end
    n_cmp++; if (count !== 16'd1) begin n_bad++; $display("FAIL basic_count: got %0d want 1", count); end
    obr = 1'b1;
    tick;
    obr = 1'b0;
    n_cmp++; if (obv !== 1'b0) begin n_bad++; $display("FAIL basic_drop: got %b want 0", obv); end
    n_cmp++; if (ifr !== 1'b1) begin n_bad++; $display("FAIL basic_idle_ifr: got %b want 1", ifr); end
  endtask

  task automatic test_target_first;
    tv = 1'b1; td = 8'hF0;
    tick;
    tv = 1'b0;
    for (int i = 1; i < 4; i++) begin
      n_cmp++; if (tr !== 1'b0) begin n_bad++; $display("FAIL tfirst_tr_c%0d: got %b want 0", i, tr); end
      n_cmp++; if (ifr !== 1'b1) begin n_bad++; $display("FAIL tfirst_ifr_c%0d: got %b want 1", i, ifr); end
      tick;
    end
    ifv = 1'b1; ifd = 8'h10; train = 1'b1;
    tick;
    ifv = 1'b0;
    n_cmp++; if (obv !== 1'b0) begin n_bad++; $display("FAIL tfirst_c5_valid: got %b want 0", obv); end
    tick;
    n_cmp++; if (obv !== 1'b1) begin n_bad++; $display("FAIL tfirst_c6_valid: got %b want 1", obv); end
    n_cmp++; if (obd !== 16'h00E0) begin n_bad++; $display("FAIL tfirst_data: got %h want 00E0", obd); end
    n_cmp++; if (loss !== 20'd66560) begin n_bad++; $display("FAIL tfirst_loss: got %0d want 66560", loss); end
    n_cmp++; if (count !== 16'd2) begin n_bad++; $display("FAIL tfirst_count: got %0d want 2", count); end
  endtask

  task automatic test_backpressure;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (obv !== 1'b1) begin n_bad++; $display("FAIL bp_valid_%0d: got %b want 1", i, obv); end
      n_cmp++; if (obd !== 16'h00E0) begin n_bad++; $display("FAIL bp_data_%0d: got %h want 00E0", i, obd); end
      n_cmp++; if (ifr !== 1'b0) begin n_bad++; $display("FAIL bp_ifr_%0d: got %b want 0", i, ifr); end
      n_cmp++; if (tr !== 1'b0) begin n_bad++; $display("FAIL bp_tr_%0d: got %b want 0", i, tr); end
      tick;
    end
    obr = 1'b1;
    tick;
    n_cmp++; if (obv !== 1'b0) begin n_bad++; $display("FAIL bp_release_valid: got %b want 0", obv); end
    n_cmp++; if (ifr !== 1'b1) begin n_bad++; $display("FAIL bp_release_ifr: got %b want 1", ifr); end
    tick;
    obr = 1'b0;
    n_cmp++; if (obv !== 1'b0) begin n_bad++; $display("FAIL bp_single_xfer: got %b want 0", obv); end
    n_cmp++; if (count !== 16'd2) begin n_bad++; $display("FAIL bp_count: got %0d want 2", count); end
  endtask

  task automatic test_inference;
    logic [W-1:0] acts [3];
    acts[0] = 8'h11; acts[1] = 8'h22; acts[2] = 8'h33;
    tv = 1'b1; td = 8'h55;
    tick;
    tv = 1'b0;
    n_cmp++; if (tr !== 1'b0) begin n_bad++; $display("FAIL inf_prebuf_tr: got %b want 0", tr); end
    train = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ifv = 1'b1; ifd = acts[i];
      n_cmp++; if (ifr !== 1'b1) begin n_bad++; $display("FAIL inf_ifr_%0d: got %b want 1", i, ifr); end
      tick;
      n_cmp++; if (obv !== 1'b0) begin n_bad++; $display("FAIL inf_valid_%0d: got %b want 0", i, obv); end
    end
    ifv = 1'b0;
    n_cmp++; if (tr !== 1'b0) begin n_bad++; $display("FAIL inf_held_tr: got %b want 0", tr); end
    n_cmp++; if (loss !== 20'd66560) begin n_bad++; $display("FAIL inf_loss: got %0d want 66560", loss); end
    n_cmp++; if (count !== 16'd2) begin n_bad++; $display("FAIL inf_count: got %0d want 2", count); end
    // The held target pairs with the next trained activation.
    ifv = 1'b1; ifd = 8'h55; train = 1'b1;
    tick;
    ifv = 1'b0;
    tick;
    n_cmp++; if (obv !== 1'b1) begin n_bad++; $display("FAIL inf_consume_valid: got %b want 1", obv); end
    n_cmp++; if (obd !== 16'h0000) begin n_bad++; $display("FAIL inf_consume_data: got %h want 0000", obd); end
    n_cmp++; if (count !== 16'd3) begin n_bad++; $display("FAIL inf_consume_count: got %0d want 3", count); end
    obr = 1'b1;
    tick;
    obr = 1'b0;
  endtask

  task automatic test_saturation;
    clear = 1'b1;
    tick;
    clear = 1'b0;
    n_cmp++; if (loss !== 20'd0) begin n_bad++; $display("FAIL sat_clear_loss: got %0d want 0", loss); end
    n_cmp++; if (count !== 16'd0) begin n_bad++; $display("FAIL sat_clear_count: got %0d want 0", count); end
    for (int i = 0; i < 17; i++) begin
      ifv = 1'b1; ifd = 8'h00; tv = 1'b1; td = 8'hFF; train = 1'b1;
      tick;
      ifv = 1'b0; tv = 1'b0;
      tick;
      n_cmp++; if (obd !== 16'h00FF) begin n_bad++; $display("FAIL sat_data_%0d: got %h want 00FF", i, obd); end
      if (i == 15) begin
        n_cmp++; if (loss !== 20'd1040400) begin n_bad++; $display("FAIL sat_loss16: got %0d want 1040400", loss); end
        n_cmp++; if (count !== 16'd16) begin n_bad++; $display("FAIL sat_count16: got %0d want 16", count); end
      end
      if (i == 16) begin
        n_cmp++; if (loss !== 20'hFFFFF) begin n_bad++; $display("FAIL sat_loss17: got %h want FFFFF", loss); end
        n_cmp++; if (count !== 16'd17) begin n_bad++; $display("FAIL sat_count17: got %0d want 17", count); end
      end
      obr = 1'b1;
      tick;
      obr = 1'b0;
    end
    ifv = 1'b1; ifd = 8'h00; tv = 1'b1; td = 8'hFF;
    tick;
    ifv = 1'b0; tv = 1'b0; clear = 1'b1;
    tick;
    clear = 1'b0;
    n_cmp++; if (obv !== 1'b1) begin n_bad++; $display("FAIL sat_clr_valid: got %b want 1", obv); end
    n_cmp++; if (loss !== 20'd0) begin n_bad++; $display("FAIL sat_clr_loss: got %0d want 0", loss); end
    n_cmp++; if (count !== 16'd0) begin n_bad++; $display("FAIL sat_clr_count: got %0d want 0", count); end
    obr = 1'b1;
    tick;
    obr = 1'b0;
  endtask

  task automatic test_reset_mid;
    ifv = 1'b1; ifd = 8'h20; tv = 1'b1; td = 8'h30; train = 1'b1;
    tick;
    ifv = 1'b0; tv = 1'b0;
    tick;
    n_cmp++; if (obv !== 1'b1) begin n_bad++; $display("FAIL rmid_pre_valid: got %b want 1", obv); end
    n_cmp++; if (loss !== 20'd256) begin n_bad++; $display("FAIL rmid_pre_loss: got %0d want 256", loss); end
    #2;
    reset = 1'b0;
    #1;
    n_cmp++; if (obv !== 1'b0) begin n_bad++; $display("FAIL rmid_valid: got %b want 0", obv); end
    n_cmp++; if (obd !== 16'h0000) begin n_bad++; $display("FAIL rmid_data: got %h want 0000", obd); end
    n_cmp++; if (loss !== 20'd0) begin n_bad++; $display("FAIL rmid_loss: got %0d want 0", loss); end
    n_cmp++; if (count !== 16'd0) begin n_bad++; $display("FAIL rmid_count: got %0d want 0", count); end
    #1;
    reset = 1'b1;
    tick;
    n_cmp++; if (ifr !== 1'b1) begin n_bad++; $display("FAIL rmid_ifr: got %b want 1", ifr); end
    n_cmp++; if (tr !== 1'b1) begin n_bad++; $display("FAIL rmid_tr: got %b want 1", tr); end
    n_cmp++; if (obv !== 1'b0) begin n_bad++; $display("FAIL rmid_post_valid: got %b want 0", obv); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_target_first;
    test_backpressure;
    test_inference;
    test_saturation;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
